branch_predictor: RTL

- Fetch-side 2-bit saturating-counter branch history table (BHT).
- Forms the prediction end of the branch decision path; the execute-stage comparator supplies the resolved outcome at the other end.
- The fetch stage queries with the branch PC and receives a taken/not-taken guess.
- The execute stage returns the comparator result plus the carried prediction. The block trains its counters and flags mispredictions to the hazard/flush logic.

---
 rtl/branch_predictor.sv | 83 ++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch history table with misprediction flag and branch statistics.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history register into the lookup index.
module branch_predictor #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             res_valid,
    input  logic [IDX_W-1:0] res_idx,
    input  logic             res_taken,
    input  logic             res_pred_taken,
    output logic             mispredict,
    output logic [31:0]      br_cnt,
    output logic [31:0]      miss_cnt
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0] bht [ENTRIES];
    logic [1:0] cur_cnt;
    logic [1:0] next_cnt;
    logic       miss_now;

    // pred_valid and the untouched PC bits are reserved; they feed nothing.
    logic unused_bits;
    assign unused_bits = &{1'b0, pred_valid, pred_pc[31:IDX_W+2], pred_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [IDX_W-1:0] ghr;
    assign pred_idx = pred_pc[IDX_W+1:2] ^ ghr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ghr <= '0;
        end else if (res_valid) begin
            ghr <= {ghr[IDX_W-2:0], res_taken};
        end
    end
`else
    assign pred_idx = pred_pc[IDX_W+1:2];
`endif

    // Lookup reads the stored value; a same-cycle update is seen next cycle.
    assign pred_taken = bht[pred_idx][1];

    assign cur_cnt  = bht[res_idx];
    assign miss_now = res_valid & (res_taken ^ res_pred_taken);

    always_comb begin
        next_cnt = cur_cnt;
        if (res_taken) begin
            if (cur_cnt != 2'b11) next_cnt = cur_cnt + 2'b01;
        end else begin
            if (cur_cnt != 2'b00) next_cnt = cur_cnt - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= CNT_INIT;
            end
            mispredict <= 1'b0;
            br_cnt     <= '0;
            miss_cnt   <= '0;
        end else begin
            mispredict <= miss_now;
            if (res_valid) begin
                bht[res_idx] <= next_cnt;
                br_cnt       <= br_cnt + 32'd1;
            end
            if (miss_now) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

endmodule
